// File: rtl/exp_sum_accumulator.sv
// Multi-lane exponent accumulator for the softmax stage: sums a vector of lane values with guard
// bits and presents acc >> GUARD. Define EXP_SUM_SATURATE_EN to clamp on overflow instead of wrap.
module exp_sum_accumulator #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned LANES     = 1,
  parameter int unsigned GUARD     = 4,
  parameter int unsigned MAX_COUNT = 16,
  localparam int unsigned ACC_W    = DATA_SIZE + GUARD,
  localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic [CNT_W-1:0]           len_i,
  input  logic [LANES*DATA_SIZE-1:0] exp_i,
  input  logic [LANES-1:0]           lane_mask_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  output logic [DATA_SIZE-1:0]       sum_o,
  output logic                       sum_valid_o,
  input  logic                       sum_ready_i,
  output logic [CNT_W-1:0]           count_o,
  output logic                       overflow_o
);

  localparam int unsigned SUM_W = ACC_W + $clog2(LANES) + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   taken;
  logic [SUM_W-1:0]   lane_sum;
  logic [SUM_W-1:0]   total;
  logic               carry;
  logic [ACC_W-1:0]   acc_upd;
  logic               begin_vec;

  // Masked lanes are taken lowest index first until the vector length is met.
  always_comb begin
    remaining = len_q - cnt_q;
    taken     = '0;
    lane_sum  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_mask_i[k] && (taken < remaining)) begin
        lane_sum = lane_sum + SUM_W'(exp_i[k*DATA_SIZE +: DATA_SIZE]);
        taken    = taken + CNT_W'(1);
      end
    end
    total = SUM_W'(acc_q) + lane_sum;
    carry = |total[SUM_W-1:ACC_W];
`ifdef EXP_SUM_SATURATE_EN
    acc_upd = (carry || ovf_q) ? {ACC_W{1'b1}} : total[ACC_W-1:0];
`else
    acc_upd = total[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    begin_vec = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin_vec = 1'b1;
      end
      StAccum: begin
        if (start_i) begin
          begin_vec = 1'b1;
        end else if (data_valid_i) begin
          acc_d = acc_upd;
          cnt_d = cnt_q + taken;
          ovf_d = ovf_q | carry;
          if (cnt_d == len_q) state_d = StHold;
        end
      end
      StHold: begin
        if (sum_ready_i) begin
          if (start_i) begin_vec = 1'b1;
          else         state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (begin_vec) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      len_d   = len_i;
      state_d = (len_i == '0) ? StHold : StAccum;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_ready_o = (state_q == StAccum);
  assign sum_valid_o  = (state_q == StHold);
  assign sum_o        = acc_q[ACC_W-1:GUARD];
  assign count_o      = cnt_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_exp_sum_accumulator.sv
// Scoreboard bench for exp_sum_accumulator: a 4-lane/GUARD=4 instance and a 1-lane/GUARD=0 one.
module tb_exp_sum_accumulator;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic            a_start, a_valid, a_ready, a_sum_valid, a_sum_ready, a_ovf;
  logic [CW-1:0]   a_len, a_count;
  logic [4*DW-1:0] a_exp;
  logic [3:0]      a_mask;
  logic [DW-1:0]   a_sum;

  logic            b_start, b_valid, b_ready, b_sum_valid, b_sum_ready, b_ovf;
  logic [CW-1:0]   b_len, b_count;
  logic [DW-1:0]   b_exp;
  logic [0:0]      b_mask;
  logic [DW-1:0]   b_sum;

  exp_sum_accumulator #(
    .DATA_SIZE(32), .LANES(4), .GUARD(4), .MAX_COUNT(16)
  ) dut_a (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(a_start), .len_i(a_len), .exp_i(a_exp),
    .lane_mask_i(a_mask), .data_valid_i(a_valid), .data_ready_o(a_ready), .sum_o(a_sum),
    .sum_valid_o(a_sum_valid), .sum_ready_i(a_sum_ready), .count_o(a_count),
    .overflow_o(a_ovf)
  );

  exp_sum_accumulator #(
    .DATA_SIZE(32), .LANES(1), .GUARD(0), .MAX_COUNT(16)
  ) dut_b (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(b_start), .len_i(b_len), .exp_i(b_exp),
    .lane_mask_i(b_mask), .data_valid_i(b_valid), .data_ready_o(b_ready), .sum_o(b_sum),
    .sum_valid_o(b_sum_valid), .sum_ready_i(b_sum_ready), .count_o(b_count),
    .overflow_o(b_ovf)
  );

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_sum_valid && a_sum_ready) begin
      if (a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_sum: got sum %0h with no pending vector", a_sum);
      end else begin
        a_e = a_q.pop_front();
        check("a_sum", 64'(a_sum), 64'(a_e.sum));
        check("a_count", 64'(a_count), 64'(a_e.cnt));
        check("a_overflow", 64'(a_ovf), 64'(a_e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_sum_valid && b_sum_ready) begin
      if (b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_sum: got sum %0h with no pending vector", b_sum);
      end else begin
        b_e = b_q.pop_front();
        check("b_sum", 64'(b_sum), 64'(b_e.sum));
        check("b_count", 64'(b_count), 64'(b_e.cnt));
        check("b_overflow", 64'(b_ovf), 64'(b_e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_go(input int len);
    a_start = 1'b1;
    a_len   = CW'(len);
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_beat(input logic [3:0] m, input logic [4*DW-1:0] d);
    a_valid = 1'b1;
    a_mask  = m;
    a_exp   = d;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic a_take();
    a_sum_ready = 1'b1;
    tick();
    a_sum_ready = 1'b0;
  endtask

  task automatic b_go(input int len);
    b_start = 1'b1;
    b_len   = CW'(len);
    tick();
    b_start = 1'b0;
  endtask

  task automatic b_beat(input logic [DW-1:0] d);
    b_valid = 1'b1;
    b_mask  = 1'b1;
    b_exp   = d;
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    a_start = 0; a_len = '0; a_exp = '0; a_mask = '0; a_valid = 0; a_sum_ready = 0;
    b_start = 0; b_len = '0; b_exp = '0; b_mask = '0; b_valid = 0; b_sum_ready = 0;
    #1 rst_n = 1'b0;
    #11;
    check("rst_ready", 64'(a_ready), 64'd0);
    check("rst_sum", 64'(a_sum), 64'd0);
    check("rst_sum_valid", 64'(a_sum_valid), 64'd0);
    check("rst_count", 64'(a_count), 64'd0);
    check("rst_overflow", 64'(a_ovf), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Basic sum, one lane used: (16+32+48+64)/16 = 10
    a_go(4);
    check("start_ready", 64'(a_ready), 64'd1);
    a_q.push_back('{sum: 32'd10, cnt: 5'd4, ovf: 1'b0});
    a_beat(4'b0001, 128'd16);
    a_beat(4'b0001, 128'd32);
    a_beat(4'b0001, 128'd48);
    check("basic_not_done", 64'(a_sum_valid), 64'd0);
    a_beat(4'b0001, 128'd64);
    check("basic_done_latency", 64'(a_sum_valid), 64'd1);
    a_take();
    check("basic_back_idle", 64'(a_sum_valid), 64'd0);

    // Excess discard: 4 + 2 lanes of 0x10 -> 0x60 -> 6
    a_go(6);
    a_q.push_back('{sum: 32'd6, cnt: 5'd6, ovf: 1'b0});
    a_beat(4'b1111, {4{32'h10}});
    check("excess_count_mid", 64'(a_count), 64'd4);
    check("excess_sum_mid", 64'(a_sum), 64'd4);
    a_beat(4'b0111, {4{32'h10}});

    // Backpressure with data_valid driven in HOLD
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1;
      a_mask  = 4'b1111;
      a_exp   = {4{32'h10}};
      check("bp_valid", 64'(a_sum_valid), 64'd1);
      check("bp_ready", 64'(a_ready), 64'd0);
      check("bp_sum", 64'(a_sum), 64'd6);
      tick();
    end
    a_valid = 1'b0;
    a_take();
    check("bp_idle_valid", 64'(a_sum_valid), 64'd0);
    check("bp_idle_ready", 64'(a_ready), 64'd0);

    // Zero-length vector goes straight to HOLD
    a_go(0);
    a_q.push_back('{sum: 32'd0, cnt: 5'd0, ovf: 1'b0});
    check("len0_valid", 64'(a_sum_valid), 64'd1);
    check("len0_ready", 64'(a_ready), 64'd0);
    a_take();

    // Restart in ACCUM; the beat alongside start is dropped
    a_go(4);
    a_beat(4'b0001, 128'h100);
    a_beat(4'b0001, 128'h100);
    check("restart_pre_count", 64'(a_count), 64'd2);
    a_valid = 1'b1;
    a_mask  = 4'b1111;
    a_exp   = {4{32'h10}};
    a_go(3);
    a_valid = 1'b0;
    a_q.push_back('{sum: 32'd3, cnt: 5'd3, ovf: 1'b0});
    check("restart_count", 64'(a_count), 64'd0);
    check("restart_sum", 64'(a_sum), 64'd0);
    check("restart_ready", 64'(a_ready), 64'd1);
    a_beat(4'b0001, 128'h10);
    a_beat(4'b0001, 128'h10);
    a_beat(4'b0001, 128'h10);
    check("restart_done", 64'(a_sum_valid), 64'd1);

    // start with sum_ready in HOLD: straight into the next vector
    a_sum_ready = 1'b1;
    a_start     = 1'b1;
    a_len       = CW'(2);
    tick();
    a_sum_ready = 1'b0;
    a_start     = 1'b0;
    a_q.push_back('{sum: 32'd7, cnt: 5'd2, ovf: 1'b0});
    check("hold_restart_ready", 64'(a_ready), 64'd1);
    check("hold_restart_valid", 64'(a_sum_valid), 64'd0);
    a_beat(4'b0000, {4{32'h55}});
    check("zero_mask_count", 64'(a_count), 64'd0);
    check("zero_mask_ready", 64'(a_ready), 64'd1);
    // lanes 0,1 = 0x40,0x30 -> 0x70 -> 7
    a_beat(4'b1111, {32'h10, 32'h20, 32'h30, 32'h40});
    check("order_done", 64'(a_sum_valid), 64'd1);
    a_take();

    // Asynchronous reset mid-vector
    a_go(4);
    a_beat(4'b0001, 128'h100);
    a_beat(4'b0001, 128'h100);
    check("pre_reset_sum", 64'(a_sum), 64'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", 64'(a_ready), 64'd0);
    check("async_sum", 64'(a_sum), 64'd0);
    check("async_valid", 64'(a_sum_valid), 64'd0);
    check("async_count", 64'(a_count), 64'd0);
    check("async_overflow", 64'(a_ovf), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    a_go(1);
    a_q.push_back('{sum: 32'd2, cnt: 5'd1, ovf: 1'b0});
    a_beat(4'b0001, 128'h20);
    a_take();

    // Overflow on GUARD=0 instance
    b_go(2);
`ifdef EXP_SUM_SATURATE_EN
    b_q.push_back('{sum: 32'hFFFF_FFFF, cnt: 5'd2, ovf: 1'b1});
`else
    b_q.push_back('{sum: 32'h0000_0001, cnt: 5'd2, ovf: 1'b1});
`endif
    b_beat(32'hFFFF_FFFF);
    check("ovf_not_yet", 64'(b_ovf), 64'd0);
    b_beat(32'h0000_0002);
    check("ovf_flag", 64'(b_ovf), 64'd1);
    check("ovf_done", 64'(b_sum_valid), 64'd1);
    b_sum_ready = 1'b1;
    tick();
    b_sum_ready = 1'b0;
    b_go(3);
    check("ovf_cleared", 64'(b_ovf), 64'd0);
    b_q.push_back('{sum: 32'd6, cnt: 5'd3, ovf: 1'b0});
    b_beat(32'd1);
    b_beat(32'd2);
    b_beat(32'd3);
    b_sum_ready = 1'b1;
    tick();
    b_sum_ready = 1'b0;

    for (int i = 0; i < 20 && (a_q.size() != 0 || b_q.size() != 0); i++) tick();
    check("a_queue_drained", 64'(a_q.size()), 64'd0);
    check("b_queue_drained", 64'(b_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_sum_accumulator.md
# exp_sum_accumulator

- Parametrised multi-lane accumulator for the softmax compute stage.
- Sums a vector of exponent values into a wide accumulator with guard bits and returns the scaled sum to the divider stage.
- Adds over the single-lane adder: a runtime vector length, LANES inputs per beat, valid/ready handshakes on both sides, and sticky overflow detection.

## Interface

- DATA_SIZE, 32, width of each exp value and of sum_o
- LANES, 1, exp values accepted per beat
- GUARD, 4, extra accumulator MSBs; ACC_W = DATA_SIZE + GUARD
- MAX_COUNT, 16, maximum elements per vector; CNT_W = $clog2(MAX_COUNT+1)

- clock_i  in  1  single clock, rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle pulse: clear accumulator, latch len_i, begin vector
- len_i  in  CNT_W  element count of the vector; legal range 0..MAX_COUNT
- exp_i  in  LANES*DATA_SIZE  lane k occupies bits [k*DATA_SIZE +: DATA_SIZE]
- lane_mask_i  in  LANES  lanes carrying data this beat
- data_valid_i  in  1  input beat valid
- data_ready_o  out  1  block accepts input beats
- sum_o  out  DATA_SIZE  acc[ACC_W-1:GUARD], i.e. accumulator / 2^GUARD, truncated
- sum_valid_o  out  1  sum_o is final
- sum_ready_i  in  1  consumer takes sum_o
- count_o  out  CNT_W  elements accumulated so far in the current vector
- overflow_o  out  1  sticky; the accumulator exceeded ACC_W bits in the current vector

## Operation

- **FSM states:** IDLE, ACCUM, HOLD. Reset state is IDLE.
- **IDLE**
  - data_ready_o=0, sum_valid_o=0.
  - start_i → clear acc, count and overflow; latch len_i.
  - If len_i==0, next state is HOLD with sum_o=0; otherwise next state is ACCUM.
- **ACCUM**
  - data_ready_o=1.
  - A beat is accepted when data_valid_i && data_ready_o.
  - Only masked lanes count, taken in ascending index order.
  - At most (len − count) lanes are added; excess masked lanes are discarded.
  - On acceptance: acc += sum of taken lanes; count_o += number of taken lanes.
  - When count reaches len, next state is HOLD.
  - A beat with an all-zero mask is accepted and adds nothing.
- **HOLD**
  - sum_valid_o=1, data_ready_o=0. sum_o, count_o and overflow_o hold stable.
  - sum_ready_i → IDLE.
- **start_i handling by state**
  - start_i in ACCUM aborts the current vector, clears acc, count and overflow, latches the new len_i, and stays in ACCUM (or goes to HOLD if len_i==0). A beat presented in the same cycle is dropped.
  - start_i in HOLD together with sum_ready_i completes the transfer and starts the new vector in the same cycle.
  - start_i in HOLD without sum_ready_i is ignored.
- **Arithmetic**
  - Lane values are unsigned; they are summed through a combinational adder tree of width ACC_W+$clog2(LANES)+1.
  - A carry out of ACC_W sets overflow_o.
- **Outputs in ACCUM:** sum_o and count_o show the running values.

## Timing

- **Reset values:** data_ready_o=0, sum_o=0, sum_valid_o=0, count_o=0, overflow_o=0, state IDLE.
- **Reset behaviour:** reset takes effect immediately on the falling edge of reset_n_i, including mid-vector and in HOLD; the partial sum is lost.
- **Start latency:** data_ready_o rises the cycle after start_i.
- **Completion latency:** sum_valid_o rises the cycle after the beat that completes len; that is one cycle of latency.
- **len_i==0:** sum_valid_o rises the cycle after start_i.
- **Throughput:** one beat per cycle, i.e. up to LANES elements per cycle.
- **Handshake rules**
  - The consumer may hold sum_ready_i low indefinitely; nothing changes meanwhile.
  - sum_ready_i outside HOLD is ignored.
  - data_valid_i outside ACCUM is ignored.

## Configuration

- **EXP_SUM_SATURATE_EN defined:** on overflow, acc clamps to all-ones (2^ACC_W − 1) and remains there for the rest of the vector; overflow_o=1.
- **EXP_SUM_SATURATE_EN undefined:** acc wraps modulo 2^ACC_W; overflow_o=1 still flags the wrap.

## Test plan

- **Basic sum:** LANES=1, GUARD=4; start_i with len=4; exps 16, 32, 48, 64 on consecutive cycles → sum_valid_o high the cycle after the 4th beat, sum_o=10, count_o=4, overflow_o=0.
- **Multi-lane excess discard:** LANES=4, len=6; beat 1 mask=1111, all lanes 0x10; beat 2 mask=0111, all lanes 0x10 → only lanes 0–1 of beat 2 added; acc=0x60, sum_o=6, count_o=6.
- **Backpressure:** hold sum_ready_i low 5 cycles in HOLD while driving data_valid_i=1 → sum_valid_o stays 1, sum_o stable, data_ready_o=0; raise sum_ready_i → IDLE the next cycle.
- **Overflow:** GUARD=0, len=2, exps 0xFFFFFFFF then 0x00000002 → without macro sum_o=0x00000001, overflow_o=1; with EXP_SUM_SATURATE_EN sum_o=0xFFFFFFFF, overflow_o=1.
- **Async reset mid-vector:** len=4, drop reset_n_i between clock edges after 2 beats → all outputs 0 immediately. After release, start_i len=1 with exp 0x20 → sum_o=2.
- **Restart:** start_i len=3 in ACCUM after 2 beats → count_o=0, then 3 beats of 0x10 → sum_o=3. Also cover start_i plus sum_ready_i in the same HOLD cycle → state goes directly to ACCUM.
